sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a pair of 16-bit asynchronous SRAM chips that together
// hold 32-bit words. Every SRAM-side and requester-side output is registered.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_50mhz,
  input  logic        reset,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [17:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [17:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,

  output logic [17:0] ram_addr,
  input  logic [31:0] ram_data_read,
  output logic [31:0] ram_data_write,
  output logic        ram_data_is_output,
  output logic [1:0]  ram_ce_n,
  output logic [1:0]  ram_ub_n,
  output logic [1:0]  ram_lb_n,
  output logic        ram_we_n,
  output logic        ram_oe_n
);

  typedef enum logic [2:0] {StIdle, StRd, StWsetup, StWr, StWhold} state_e;

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        sel;
  logic        done;
  logic        active;

  logic [17:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        drive_q, drive_d;
  logic [1:0]  ce_n_q, ce_n_d;
  logic [1:0]  ub_n_q, ub_n_d;
  logic [1:0]  lb_n_q, lb_n_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    sel     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          // A contested grant goes to the port that was not served last.
          sel     = (p0_req && p1_req) ? ~last_q : p1_req;
          gnt_d   = sel;
          last_d  = sel;
          addr_d  = sel ? p1_addr : p0_addr;
          wdata_d = sel ? p1_wdata : p0_wdata;
          be_d    = sel ? p1_be : p0_be;
          state_d = (sel ? p1_we : p0_we) ? StWsetup : StRd;
          cnt_d   = CntLoad;
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWsetup: begin
        state_d = StWr;
        cnt_d   = CntLoad;
      end
      StWr: begin
        if (cnt_q == 4'd0) begin
          state_d = StWhold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWhold: begin
        state_d = StIdle;
        done    = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of what the next state requires, so pins change on the edge
  // that enters each state.
  always_comb begin
    active      = (state_d != StIdle);
    drive_d     = (state_d == StWsetup) || (state_d == StWr) || (state_d == StWhold);
    ram_addr_d  = active ? addr_d : ram_addr_q;
    ram_wdata_d = drive_d ? wdata_d : ram_wdata_q;
    ce_n_d      = active ? {~|be_d[3:2], ~|be_d[1:0]} : 2'b11;
    lb_n_d      = active ? {~be_d[2], ~be_d[0]} : 2'b11;
    ub_n_d      = active ? {~be_d[3], ~be_d[1]} : 2'b11;
    oe_n_d      = (state_d != StRd);
    we_n_d      = (state_d != StWr);
    ack0_d      = done & ~gnt_q;
    ack1_d      = done & gnt_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    // A read with no enabled byte leaves the previous data in place.
    if (done && (state_q == StRd) && (be_q != 4'd0)) begin
      if (gnt_q) rdata1_d = ram_data_read;
      else       rdata0_d = ram_data_read;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= 18'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      ram_addr_q  <= 18'd0;
      ram_wdata_q <= 32'd0;
      drive_q     <= 1'b0;
      ce_n_q      <= 2'b11;
      ub_n_q      <= 2'b11;
      lb_n_q      <= 2'b11;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      drive_q     <= drive_d;
      ce_n_q      <= ce_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ram_addr           = ram_addr_q;
  assign ram_data_write     = ram_wdata_q;
  assign ram_data_is_output = drive_q;
  assign ram_ce_n           = ce_n_q;
  assign ram_ub_n           = ub_n_q;
  assign ram_lb_n           = lb_n_q;
  assign ram_we_n           = we_n_q;
  assign ram_oe_n           = oe_n_q;
  assign p0_ack             = ack0_q;
  assign p1_ack             = ack1_q;
  assign p0_rdata           = rdata0_q;
  assign p1_rdata           = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a word-wide SRAM model with byte lanes, a reference memory and
// requester tasks that drive single, back-to-back, contested and random accesses.
module tb_sram_arbiter;
  localparam int unsigned W = 2;

  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic        reset;
  logic [1:0]  req, we, ack;
  logic [17:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic [31:0] rdata [2];
  logic [17:0] ram_addr;
  logic [31:0] ram_data_read, ram_data_write;
  logic        ram_data_is_output, ram_we_n, ram_oe_n;
  logic [1:0]  ram_ce_n, ram_ub_n, ram_lb_n;

  int vectors = 0;
  int miscompares = 0;
  int acks [2] = '{0, 0};

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_be(be[0]),
    .p0_ack(ack[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_be(be[1]),
    .p1_ack(ack[1]), .p1_rdata(rdata[1]),
    .ram_addr(ram_addr), .ram_data_read(ram_data_read), .ram_data_write(ram_data_write),
    .ram_data_is_output(ram_data_is_output), .ram_ce_n(ram_ce_n), .ram_ub_n(ram_ub_n),
    .ram_lb_n(ram_lb_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
  );

  // SRAM pair: chip i holds bits 16i+15:16i, lb = low byte, ub = high byte.
  logic [31:0] mem [0:262143];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  assign ram_data_read = mem[ram_addr];
  always @(posedge clk_50mhz) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ram_we_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!ram_ce_n[i] && !ram_lb_n[i]) mem[ram_addr][16*i +: 8] <= ram_data_write[16*i +: 8];
        if (!ram_ce_n[i] && !ram_ub_n[i]) mem[ram_addr][16*i+8 +: 8] <= ram_data_write[16*i+8 +: 8];
      end
    end
  end

  logic [31:0] ref_mem [logic [17:0]];
  logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

  function automatic void model_write(input logic [17:0] a, input logic [31:0] d,
                                      input logic [3:0] b);
    logic [31:0] t;
    t = ref_mem[a];
    for (int i = 0; i < 4; i++) if (b[i]) t[8*i +: 8] = d[8*i +: 8];
    ref_mem[a] = t;
  endfunction

  // Per-cycle protocol invariants.
  always @(negedge clk_50mhz) begin
    vectors++;
    if ((!ram_oe_n && !ram_we_n) || (!ram_oe_n && ram_data_is_output) || (ack === 2'b11)) begin
      miscompares++;
      $display("FAIL invariant t=%0t oe_n=%b we_n=%b is_out=%b ack=%b (no overlap, no drive on read, one ack)",
               $time, ram_oe_n, ram_we_n, ram_data_is_output, ack);
    end
    if (ack[0] === 1'b1) acks[0]++;
    if (ack[1] === 1'b1) acks[1]++;
  end

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic preload(input logic [17:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one access; cyc counts cycles from the sampling cycle to the ack cycle.
  task automatic access(input int p, input logic w, input logic [17:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output int cyc);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ack[p] !== 1'b1 && cyc < 200);
    rd = rdata[p];
    req[p] = 1'b0;
  endtask

  // Single access from idle with every strobe checked in every cycle up to the ack.
  task automatic trace_access(input int p, input logic w, input logic [17:0] a,
                              input logic [31:0] d, input logic [3:0] b);
    int last;
    logic act, wr, rdc;
    logic [1:0] ce_e, lb_e, ub_e;
    logic [10:0] exp_s, got_s;
    ce_e = {~|b[3:2], ~|b[1:0]};
    lb_e = {~b[2], ~b[0]};
    ub_e = {~b[3], ~b[1]};
    last = w ? W + 3 : W + 1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    for (int c = 1; c <= last; c++) begin
      tick();
      act = (c < last);
      rdc = !w && act;
      wr  = w && (c >= 2) && (c <= W + 1);
      exp_s = {act ? ce_e : 2'b11, act ? ub_e : 2'b11, act ? lb_e : 2'b11, !wr, !rdc,
               w && act, c == last, 1'b0};
      got_s = {ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n, ram_data_is_output,
               ack[p], ack[1-p]};
      vectors++;
      if (got_s !== exp_s) begin
        miscompares++;
        $display("FAIL trace p%0d we=%b cycle %0d: {ce,ub,lb,we,oe,out,ack,oack}=%b required %b",
                 p, w, c, got_s, exp_s);
      end
      if (act) begin
        vectors++;
        if (ram_addr !== a || (w && ram_data_write !== d)) begin
          miscompares++;
          $display("FAIL trace_bus cycle %0d: addr=%h data=%h required addr=%h data=%h",
                   c, ram_addr, ram_data_write, a, d);
        end
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({ram_addr, ram_data_write, ram_data_is_output, ram_ce_n, ram_ub_n, ram_lb_n,
         ram_we_n, ram_oe_n, ack} !== {18'd0, 32'd0, 1'b0, 6'b111111, 2'b11, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_bus addr=%h data=%h out=%b ce=%b ub=%b lb=%b we=%b oe=%b ack=%b",
               ram_addr, ram_data_write, ram_data_is_output, ram_ce_n, ram_ub_n, ram_lb_n,
               ram_we_n, ram_oe_n, ack);
    end
    vectors++;
    if (rdata[0] !== 32'd0 || rdata[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rdata got %h/%h required 0/0", rdata[0], rdata[1]);
    end
  endtask

  task automatic test_read();
    preload(18'h00010, 32'hDEADBEEF);
    trace_access(0, 1'b0, 18'h00010, 32'd0, 4'hF);
    exp_rd[0] = 32'hDEADBEEF;
    vectors++;
    if (rdata[0] !== exp_rd[0]) begin
      miscompares++;
      $display("FAIL read_data got %h required %h", rdata[0], exp_rd[0]);
    end
  endtask

  task automatic test_write();
    logic [31:0] rd;
    int cyc;
    preload(18'h3FFFF, 32'hAAAAAAAA);
    trace_access(1, 1'b1, 18'h3FFFF, 32'h12345678, 4'b0100);
    model_write(18'h3FFFF, 32'h12345678, 4'b0100);
    access(0, 1'b0, 18'h3FFFF, 32'd0, 4'hF, rd, cyc);
    exp_rd[0] = ref_mem[18'h3FFFF];
    vectors++;
    if (rd !== exp_rd[0] || cyc != W + 1) begin
      miscompares++;
      $display("FAIL write_readback got %h lat %0d required %h lat %0d",
               rd, cyc, exp_rd[0], W + 1);
    end
  endtask

  task automatic test_zero_be();
    preload(18'h00020, 32'h55AA55AA);
    trace_access(0, 1'b0, 18'h00020, 32'd0, 4'b0000);
    vectors++;
    if (rdata[0] !== exp_rd[0]) begin
      miscompares++;
      $display("FAIL zero_be_rdata got %h required previous %h", rdata[0], exp_rd[0]);
    end
    trace_access(1, 1'b1, 18'h00020, 32'hFFFFFFFF, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [17:0] a;
    logic [31:0] rd;
    int cyc;
    for (int i = 0; i < 6; i++) preload(18'h00400 + 18'(i), $urandom);
    for (int i = 0; i < 6; i++) begin
      a = 18'h00400 + 18'(i);
      access(0, 1'b0, a, 32'd0, 4'hF, rd, cyc);
      vectors++;
      if (rd !== ref_mem[a] || cyc != W + 1) begin
        miscompares++;
        $display("FAIL back_to_back #%0d got %h lat %0d required %h lat %0d",
                 i, rd, cyc, ref_mem[a], W + 1);
      end
    end
  endtask

  task automatic test_tie();
    int order [$];
    int exp_order [4] = '{0, 1, 0, 1};
    preload(18'h00500, 32'h01010101);
    preload(18'h00501, 32'h02020202);
    apply_reset();
    fork
      for (int k = 0; k < 2; k++) begin
        logic [31:0] rd;
        int cyc;
        access(0, 1'b0, 18'h00500, 32'd0, 4'hF, rd, cyc);
        order.push_back(0);
      end
      for (int k = 0; k < 2; k++) begin
        logic [31:0] rd;
        int cyc;
        access(1, 1'b0, 18'h00501, 32'd0, 4'hF, rd, cyc);
        order.push_back(1);
      end
    join
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= order.size() || order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL tie_order slot %0d got %0d required %0d",
                 i, (i < order.size()) ? order[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic port_seq(input int p, input int n);
    logic [17:0] a;
    logic [31:0] d, rd;
    logic [3:0] b;
    logic w;
    int cyc;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = 18'(32'h100 + 2 * $urandom_range(0, 7) + 32'(p));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      b = w ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
      access(p, w, a, d, b, rd, cyc);
      vectors++;
      if (cyc > 2 * W + 6) begin
        miscompares++;
        $display("FAIL random_latency p%0d #%0d waited %0d cycles, limit %0d", p, i, cyc, 2 * W + 6);
      end else if (!w && rd !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL random_read p%0d #%0d addr %h got %h required %h", p, i, a, rd, ref_mem[a]);
      end
      if (w) model_write(a, d, b);
    end
  endtask

  task automatic test_random();
    int base [2];
    for (int i = 0; i < 16; i++) preload(18'h00100 + 18'(i), $urandom);
    base[0] = acks[0];
    base[1] = acks[1];
    fork
      port_seq(0, 25);
      port_seq(1, 25);
    join
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (acks[p] - base[p] != 25) begin
        miscompares++;
        $display("FAIL random_ack_count p%0d got %0d required 25", p, acks[p] - base[p]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    int cyc, stray;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 18'h00200; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
    tick();
    tick();
    vectors++;
    if (ram_we_n !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_precondition we_n=%b required 0 in first strobe cycle", ram_we_n);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req[1] = 1'b0;
    vectors++;
    if ({ram_we_n, ram_oe_n, ram_data_is_output, ram_ce_n, ack} !== {3'b110, 2'b11, 2'b00}) begin
      miscompares++;
      $display("FAIL abort_strobes {we_n,oe_n,out,ce_n,ack}=%b required 1101100",
               {ram_we_n, ram_oe_n, ram_data_is_output, ram_ce_n, ack});
    end
    stray = 0;
    repeat (W + 4) begin
      tick();
      if (ack !== 2'b00) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL abort_no_ack got %0d ack cycles required 0", stray);
    end
    access(1, 1'b0, 18'h00010, 32'd0, 4'hF, rd, cyc);
    vectors++;
    if (rd !== ref_mem[18'h00010] || cyc != W + 1) begin
      miscompares++;
      $display("FAIL after_abort got %h lat %0d required %h lat %0d",
               rd, cyc, ref_mem[18'h00010], W + 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; be[p] = '0;
    end
    test_reset();
    test_read();
    test_write();
    test_zero_be();
    test_back_to_back();
    test_tie();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
